// File: rtl/demux_reg_bank.sv
// demux_reg_bank: steers a valid/ready write stream into one of 2**SEL_WIDTH
// registered lanes. Each lane holds its data until overwritten, tracks whether
// a consumer still has to pick it up (lane_full), and pulses lane_strobe for
// one cycle after it loads. Optionally lane 0 is a hardwired-zero sink that
// swallows writes.
module demux_reg_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 1,
    parameter bit ZERO_LANE0 = 1'b0,
    localparam int N         = 2 ** SEL_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SEL_WIDTH-1:0]          selector,
    input  logic [DATA_WIDTH-1:0]         Entrada,
    input  logic [N-1:0]                  lane_ack,
    output logic [N-1:0][DATA_WIDTH-1:0]  Saidas,
    output logic [N-1:0]                  lane_full,
    output logic [N-1:0]                  lane_strobe,
    output logic [15:0]                   xfer_count
);

    logic          accept;
    logic [N-1:0]  wr_onehot;
    logic [15:0]   count_q;

    // A lane can take new data when empty or when its consumer is draining it
    // in the same cycle; the zero sink never back-pressures.
    always_comb begin
        in_ready = ~lane_full[selector] | lane_ack[selector];
        if (ZERO_LANE0 && (selector == '0)) begin
            in_ready = 1'b1;
        end
    end

    assign accept    = in_valid & in_ready;
    assign wr_onehot = accept ? (N'(1) << selector) : '0;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            if (ZERO_LANE0 && (i == 0)) begin : g_zero
                assign Saidas[i]      = '0;
                assign lane_full[i]   = 1'b0;
                assign lane_strobe[i] = 1'b0;
            end else begin : g_reg
                logic [DATA_WIDTH-1:0] data_q;
                logic                  full_q;
                logic                  strobe_q;

                // Load on an accepted write (which also wins over a same-cycle
                // ack, keeping the lane full); otherwise an ack drains it.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        data_q   <= '0;
                        full_q   <= 1'b0;
                        strobe_q <= 1'b0;
                    end else begin
                        strobe_q <= wr_onehot[i];
                        if (wr_onehot[i]) begin
                            data_q <= Entrada;
                            full_q <= 1'b1;
                        end else if (lane_ack[i]) begin
                            full_q <= 1'b0;
                        end
                    end
                end

                assign Saidas[i]      = data_q;
                assign lane_full[i]   = full_q;
                assign lane_strobe[i] = strobe_q;
            end
        end
    endgenerate

    // Every accepted write is counted, including ones swallowed by the sink;
    // the 16-bit counter wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign xfer_count = count_q;

endmodule

// File: tb/tb_demux_reg_bank.sv
// Directed testbench for demux_reg_bank: one normal two-lane instance and one
// two-lane instance with the zero sink on lane 0, sharing clock and reset.
module tb_demux_reg_bank;

    logic              clk;
    logic              reset;

    logic              in_valid;
    logic              in_ready;
    logic [0:0]        selector;
    logic [31:0]       Entrada;
    logic [1:0]        lane_ack;
    logic [1:0][31:0]  Saidas;
    logic [1:0]        lane_full;
    logic [1:0]        lane_strobe;
    logic [15:0]       xfer_count;

    logic              z_in_valid;
    logic              z_in_ready;
    logic [0:0]        z_selector;
    logic [31:0]       z_entrada;
    logic [1:0]        z_lane_ack;
    logic [1:0][31:0]  z_saidas;
    logic [1:0]        z_lane_full;
    logic [1:0]        z_lane_strobe;
    logic [15:0]       z_xfer_count;

    int total;
    int bad;

    demux_reg_bank #(.DATA_WIDTH(32), .SEL_WIDTH(1), .ZERO_LANE0(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .selector(selector), .Entrada(Entrada), .lane_ack(lane_ack),
        .Saidas(Saidas), .lane_full(lane_full), .lane_strobe(lane_strobe),
        .xfer_count(xfer_count)
    );

    demux_reg_bank #(.DATA_WIDTH(32), .SEL_WIDTH(1), .ZERO_LANE0(1'b1)) u_zdut (
        .clk(clk), .reset(reset),
        .in_valid(z_in_valid), .in_ready(z_in_ready),
        .selector(z_selector), .Entrada(z_entrada), .lane_ack(z_lane_ack),
        .Saidas(z_saidas), .lane_full(z_lane_full), .lane_strobe(z_lane_strobe),
        .xfer_count(z_xfer_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [31:0] d,
                                 input logic [1:0] a);
        in_valid = v;
        selector = s;
        Entrada  = d;
        lane_ack = a;
        #1;
    endtask

    task automatic applyZero(input logic v, input logic s, input logic [31:0] d,
                             input logic [1:0] a);
        z_in_valid = v;
        z_selector = s;
        z_entrada  = d;
        z_lane_ack = a;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        applyZero(1'b0, 1'b0, 32'h0, 2'b00);

        // Reset state before any clock edge
        #1;
        checkOutput("rst_saidas0", Saidas[0], 32'h0);
        checkOutput("rst_saidas1", Saidas[1], 32'h0);
        checkOutput("rst_full", {30'b0, lane_full}, 32'h0);
        checkOutput("rst_strobe", {30'b0, lane_strobe}, 32'h0);
        checkOutput("rst_count", {16'b0, xfer_count}, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0, 2'b00);
        checkOutput("rst_ready", {31'b0, in_ready}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        tick();
        #2 reset = 1'b0;
        tick();

        // Basic write to lane 1
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 2'b00);
        checkOutput("w1_ready", {31'b0, in_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("w1_saidas1", Saidas[1], 32'hDEADBEEF);
        checkOutput("w1_saidas0", Saidas[0], 32'h0);
        checkOutput("w1_full", {30'b0, lane_full}, 32'h2);
        checkOutput("w1_strobe", {30'b0, lane_strobe}, 32'h2);
        checkOutput("w1_count", {16'b0, xfer_count}, 32'h1);
        tick();
        checkOutput("w1_strobe_end", {30'b0, lane_strobe}, 32'h0);
        checkOutput("w1_full_hold", {30'b0, lane_full}, 32'h2);

        // Back-pressure on a full lane, then write-through with ack
        applyStimulus(1'b1, 1'b1, 32'h11, 2'b00);
        checkOutput("bp_ready", {31'b0, in_ready}, 32'h0);
        tick();
        checkOutput("bp_saidas1", Saidas[1], 32'hDEADBEEF);
        checkOutput("bp_count", {16'b0, xfer_count}, 32'h1);
        checkOutput("bp_strobe", {30'b0, lane_strobe}, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h11, 2'b10);
        checkOutput("wt_ready", {31'b0, in_ready}, 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("wt_saidas1", Saidas[1], 32'h11);
        checkOutput("wt_full", {30'b0, lane_full}, 32'h2);
        checkOutput("wt_strobe", {30'b0, lane_strobe}, 32'h2);
        checkOutput("wt_count", {16'b0, xfer_count}, 32'h2);

        // Ack alone drains lane 1 but keeps its data
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b10);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("ack_full", {30'b0, lane_full}, 32'h0);
        checkOutput("ack_saidas1", Saidas[1], 32'h11);
        checkOutput("ack_strobe", {30'b0, lane_strobe}, 32'h0);

        // Ack on an empty lane does nothing
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b01);
        tick();
        checkOutput("ackempty_full", {30'b0, lane_full}, 32'h0);
        checkOutput("ackempty_saidas0", Saidas[0], 32'h0);

        // Selector/data ignored while in_valid is low
        applyStimulus(1'b0, 1'b1, 32'hABCD, 2'b00);
        tick();
        checkOutput("idle_saidas1", Saidas[1], 32'h11);
        checkOutput("idle_count", {16'b0, xfer_count}, 32'h2);
        checkOutput("idle_strobe", {30'b0, lane_strobe}, 32'h0);

        // Lane 0 write leaves lane 1 alone; back-to-back writes with acks
        applyStimulus(1'b1, 1'b0, 32'hCAFE0000, 2'b00);
        tick();
        checkOutput("l0_saidas0", Saidas[0], 32'hCAFE0000);
        checkOutput("l0_saidas1", Saidas[1], 32'h11);
        checkOutput("l0_full", {30'b0, lane_full}, 32'h1);
        checkOutput("l0_strobe", {30'b0, lane_strobe}, 32'h1);
        checkOutput("l0_count", {16'b0, xfer_count}, 32'h3);
        applyStimulus(1'b1, 1'b0, 32'h1, 2'b01);
        tick();
        checkOutput("b2b1_saidas0", Saidas[0], 32'h1);
        checkOutput("b2b1_strobe", {30'b0, lane_strobe}, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h2, 2'b01);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("b2b2_saidas0", Saidas[0], 32'h2);
        checkOutput("b2b2_strobe", {30'b0, lane_strobe}, 32'h1);
        checkOutput("b2b2_count", {16'b0, xfer_count}, 32'h5);
        tick();
        checkOutput("b2b_strobe_end", {30'b0, lane_strobe}, 32'h0);
        checkOutput("b2b_full", {30'b0, lane_full}, 32'h1);

        // Asynchronous reset between edges with both lanes full
        applyStimulus(1'b1, 1'b1, 32'h77, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("pre_full", {30'b0, lane_full}, 32'h3);
        #2 reset = 1'b1;
        #1;
        checkOutput("ar_saidas0", Saidas[0], 32'h0);
        checkOutput("ar_saidas1", Saidas[1], 32'h0);
        checkOutput("ar_full", {30'b0, lane_full}, 32'h0);
        checkOutput("ar_count", {16'b0, xfer_count}, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0, 2'b00);
        checkOutput("ar_ready", {31'b0, in_ready}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        @(posedge clk);
        #3 reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'h99, 2'b00);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("post_saidas1", Saidas[1], 32'h99);
        checkOutput("post_count", {16'b0, xfer_count}, 32'h1);

        // Zero sink on lane 0
        applyZero(1'b1, 1'b0, 32'h5, 2'b00);
        checkOutput("z_ready", {31'b0, z_in_ready}, 32'h1);
        tick();
        checkOutput("z_saidas0", z_saidas[0], 32'h0);
        checkOutput("z_full", {30'b0, z_lane_full}, 32'h0);
        checkOutput("z_strobe", {30'b0, z_lane_strobe}, 32'h0);
        checkOutput("z_count", {16'b0, z_xfer_count}, 32'h1);
        applyZero(1'b1, 1'b1, 32'h33, 2'b00);
        tick();
        applyZero(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("z_saidas1", z_saidas[1], 32'h33);
        checkOutput("z_strobe1", {30'b0, z_lane_strobe}, 32'h2);
        checkOutput("z_count2", {16'b0, z_xfer_count}, 32'h2);

        // Counter wrap: 65533 more sink writes reach 0xFFFF, one more wraps
        applyZero(1'b1, 1'b0, 32'h5, 2'b00);
        repeat (65533) @(posedge clk);
        #1;
        checkOutput("wrap_ffff", {16'b0, z_xfer_count}, 32'hFFFF);
        tick();
        applyZero(1'b0, 1'b0, 32'h0, 2'b00);
        checkOutput("wrap_zero", {16'b0, z_xfer_count}, 32'h0);
        checkOutput("wrap_saidas0", z_saidas[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_reg_bank.md
DEMUX_REG_BANK -- requirements
Module: demux_reg_bank

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, lane data width in bits.
REQ-002 The block SHALL have parameter SEL_WIDTH, default 1, selector width; lane count N = 2**SEL_WIDTH.
REQ-003 The block SHALL have parameter ZERO_LANE0, default 0; when 1, lane 0 is a hardwired-zero sink.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1, Entrada/selector hold a write request.
REQ-008 The block SHALL have port in_ready, output, 1, the request is accepted this cycle if in_valid.
REQ-009 The block SHALL have port selector, input, SEL_WIDTH, destination lane index.
REQ-010 The block SHALL have port Entrada, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port lane_ack, input, N, per-lane consumer acknowledge (clears full).
REQ-012 The block SHALL have port Saidas, output, N x DATA_WIDTH packed array, registered lane data.
REQ-013 The block SHALL have port lane_full, output, N, lane holds unconsumed data.
REQ-014 The block SHALL have port lane_strobe, output, N, one-cycle pulse the cycle after a lane loads.
REQ-015 The block SHALL have port xfer_count, output, 16, count of accepted writes.

Function
REQ-016 in_ready SHALL be combinational: 1 when lane_full[selector]=0 or lane_ack[selector]=1; always 1 when ZERO_LANE0=1 and selector=0.
REQ-017 A write SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; no other cycle changes Saidas.
REQ-018 On acceptance, Saidas[selector] SHALL load Entrada at that edge (latency 1; visible the following cycle) and lane_full[selector] SHALL become 1.
REQ-019 Non-selected lanes SHALL hold their data on every accepted write.
REQ-020 lane_ack[i]=1 with no acceptance to lane i SHALL clear lane_full[i] at the edge; Saidas[i] retains its value.
REQ-021 Acceptance and lane_ack on the same lane in one cycle SHALL load the new data and leave lane_full=1 (write-through).
REQ-022 lane_ack on an empty lane SHALL have no effect.
REQ-023 lane_strobe[i] SHALL be 1 for exactly the cycle after an accepted write to lane i; back-to-back writes to lane i (with acks) give consecutive strobe cycles.
REQ-024 With ZERO_LANE0=1: Saidas[0] SHALL be constant 0, lane_full[0] and lane_strobe[0] constant 0, writes to lane 0 accepted and discarded but counted.
REQ-025 xfer_count SHALL increment by 1 per accepted write, wrapping 16'hFFFF -> 0.
REQ-026 in_valid=0 SHALL change no state other than ack-driven clears.
REQ-027 selector and Entrada SHALL be ignored when in_valid=0.

Reset
REQ-028 While reset=1, all Saidas lanes, lane_full, lane_strobe and xfer_count SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard pending lane contents immediately; the first edge after deassertion may accept a write.
REQ-030 in_ready SHALL evaluate from reset lane_full values (all lanes ready) during and after reset.

Verification
REQ-031 Reset, then write 0xDEADBEEF to lane 1 (SEL_WIDTH=1) -> next cycle Saidas[1]=0xDEADBEEF, lane_full=2'b10, lane_strobe=2'b10 for 1 cycle, xfer_count=1, Saidas[0]=0.
REQ-032 Lane 1 full, in_valid=1 selector=1 Entrada=0x11 with no ack -> in_ready=0, Saidas[1] unchanged, xfer_count unchanged; assert lane_ack[1] same cycle -> accepted, Saidas[1]=0x11, lane_full[1]=1.
REQ-033 lane_ack[1] alone on full lane 1 -> lane_full[1]=0 next cycle, Saidas[1] holds prior data, no strobe.
REQ-034 ZERO_LANE0=1, write 0x5 to lane 0 -> in_ready=1, Saidas[0]=0, lane_full[0]=0, no strobe, xfer_count+1.
REQ-035 Preload xfer_count to 0xFFFF via 65535 writes with acks, one more write -> xfer_count=0.
REQ-036 Assert reset asynchronously between edges with lanes full -> all outputs 0 before next clk edge; first post-reset write accepted.
